// File: rtl/hacd_pkg.sv
// Shared HACD write-path types and helpers: AXI write request/ready/response packets, the W beat,
// the response codes and the byte-swap and clogb2 helpers.
package hacd_pkg;

  parameter logic [63:0] HAWK_ATT_START  = 64'h0000_0000_0010_0000;
  parameter logic [1:0]  AXI_RESP_OKAY   = 2'b00;
  parameter logic [1:0]  AXI_RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [63:0]  addr;
    logic [511:0] data;
    logic [63:0]  strb;
    logic         awvalid;
    logic         wvalid;
  } axi_wr_reqpkt_t;

  typedef struct packed {
    logic awready;
    logic wready;
  } axi_wr_rdypkt_t;

  typedef struct packed {
    logic [1:0] bresp;
    logic       bvalid;
  } axi_wr_resppkt_t;

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  strb;
  } axi_wr_beat_t;

  typedef enum logic {
    B_IDLE = 1'b0,
    B_RESP = 1'b1
  } b_state_e;

  function automatic int clogb2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r == 0) ? 1 : r;
  endfunction

  // Reverse byte order inside each 8-byte lane (big-endian CPU image).
  function automatic logic [511:0] get_8byte_byteswap(input logic [511:0] d);
    logic [511:0] r;
    r = '0;
    for (int l = 0; l < 8; l++) begin
      for (int b = 0; b < 8; b++) begin
        r[64*l + 8*b +: 8] = d[64*l + 8*(7-b) +: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] get_strb_swap(input logic [63:0] s);
    logic [63:0] r;
    r = '0;
    for (int l = 0; l < 8; l++) begin
      for (int b = 0; b < 8; b++) begin
        r[8*l + b] = s[8*l + (7-b)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hawk_sync_fifo.sv
// Generic synchronous FIFO, power-of-two depth, head shown while non-empty; zero-latency pop of head.
// Push is ignored when full and pop when empty, so callers gate with full/empty.
module hawk_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/hawk_axiwr_slave.sv
// AXI-style write responder committing 64-byte lines into a local window store; bvalid two edges after AW+W accept.
// A stalled B response blocks commits until the AW/W FIFOs fill and drop ready; HAWK_WR_BYTESWAP_EN swaps bytes per 8-byte lane.
module hawk_axiwr_slave
  import hacd_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR   = HAWK_ATT_START,
  parameter int          DEPTH_LINES = 64,
  parameter int          FIFO_DEPTH  = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  axi_wr_reqpkt_t                 wr_req,
  output axi_wr_rdypkt_t                 wr_rdy,
  input  logic                           bready,
  output axi_wr_resppkt_t                wr_resp,
  input  logic [clogb2(DEPTH_LINES)-1:0] dbg_idx,
  output logic [511:0]                   dbg_data
);

  localparam int          IW      = clogb2(DEPTH_LINES);
  localparam logic [57:0] DEPTH_L = 58'(DEPTH_LINES);

  logic         aw_push, aw_full, aw_empty;
  logic [63:0]  aw_head;
  logic         w_push, w_full, w_empty;
  axi_wr_beat_t w_in, w_head;

  logic         rdy_en_q, rdy_en_d;
  b_state_e     state_q, state_d;
  logic [1:0]   bresp_q, bresp_d;
  logic [511:0] dbg_data_q, dbg_data_d;

  logic         bvalid, commit, in_range;
  logic [63:0]  off;
  logic [IW-1:0] idx;
  logic [511:0] st_data;
  logic [63:0]  st_strb;
  logic [1:0]   resp;

  logic [511:0] line_mem [DEPTH_LINES];

  // Ready is held low through reset and the first edge after it.
  always_comb begin
    rdy_en_d       = 1'b1;
    wr_rdy         = '0;
    wr_rdy.awready = rdy_en_q && !aw_full;
    wr_rdy.wready  = rdy_en_q && !w_full;
  end

  assign aw_push   = wr_req.awvalid && wr_rdy.awready;
  assign w_push    = wr_req.wvalid && wr_rdy.wready;
  assign w_in.data = wr_req.data;
  assign w_in.strb = wr_req.strb;

  hawk_sync_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_aw_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (aw_push),
    .push_dat (wr_req.addr),
    .pop      (commit),
    .head     (aw_head),
    .full     (aw_full),
    .empty    (aw_empty)
  );

  hawk_sync_fifo #(.WIDTH($bits(axi_wr_beat_t)), .DEPTH(FIFO_DEPTH)) u_w_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (w_push),
    .push_dat (w_in),
    .pop      (commit),
    .head     (w_head),
    .full     (w_full),
    .empty    (w_empty)
  );

  assign bvalid = (state_q == B_RESP);
  assign commit = !aw_empty && !w_empty && (!bvalid || bready);

  always_comb begin
    off      = aw_head - BASE_ADDR;
    idx      = off[6 +: IW];
    in_range = (aw_head >= BASE_ADDR) && (off[63:6] < DEPTH_L) && (aw_head[5:0] == 6'd0);
    resp     = in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
`ifdef HAWK_WR_BYTESWAP_EN
    st_data  = get_8byte_byteswap(w_head.data);
    st_strb  = get_strb_swap(w_head.strb);
`else
    st_data  = w_head.data;
    st_strb  = w_head.strb;
`endif
  end

  always_ff @(posedge clk) begin
    if (commit && in_range) begin
      for (int b = 0; b < 64; b++) begin
        if (st_strb[b]) line_mem[idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    bresp_d    = bresp_q;
    dbg_data_d = line_mem[dbg_idx];
    case (state_q)
      B_IDLE: begin
        if (commit) begin
          state_d = B_RESP;
          bresp_d = resp;
        end
      end
      B_RESP: begin
        if (commit) begin
          bresp_d = resp;
        end else if (bready) begin
          state_d = B_IDLE;
        end
      end
      default: state_d = B_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_en_q   <= 1'b0;
      state_q    <= B_IDLE;
      bresp_q    <= 2'b00;
      dbg_data_q <= '0;
    end else begin
      rdy_en_q   <= rdy_en_d;
      state_q    <= state_d;
      bresp_q    <= bresp_d;
      dbg_data_q <= dbg_data_d;
    end
  end

  always_comb begin
    wr_resp        = '0;
    wr_resp.bvalid = bvalid;
    wr_resp.bresp  = bresp_q;
  end

  assign dbg_data = dbg_data_q;

endmodule
